// File: rtl/mult_pkg.sv
// Shared types and constants for the iterative shift-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } mult_state_t;

  localparam int unsigned MULT_STEPS = 32;
  localparam int unsigned MULT_CNT_W = 6;

endpackage

// File: rtl/mult_datapath.sv
// Combinational radix-2 shift-add step on {carry, P, M} and the final
// sign fix-up of the accumulated magnitude product.
module mult_datapath
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   p_i,
  input  logic [WIDTH-1:0]   m_i,
  input  logic               neg_i,
  output logic [WIDTH-1:0]   p_o,
  output logic [WIDTH-1:0]   m_o,
  output logic [2*WIDTH-1:0] prod_o
);

  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc;

  always_comb begin
    sum    = {1'b0, p_i} + (m_i[0] ? {1'b0, a_i} : '0);
    // carry moves into P's MSB, P's LSB into M's MSB
    p_o    = sum[WIDTH:1];
    m_o    = {sum[0], m_i[WIDTH-1:1]};
    acc    = {p_i, m_i};
    prod_o = neg_i ? (~acc + (2*WIDTH)'(1)) : acc;
  end

endmodule

// File: rtl/mult_unit.sv
// Iterative 32x32 signed/unsigned multiplier with architectural HI/LO,
// committing 33 cycles after start and accepting mthi/mtlo writes.
module mult_unit
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_multE,
  input  logic             signedE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic             mthiW,
  input  logic             mtloW,
  input  logic [WIDTH-1:0] wdataW,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  mult_state_t           state_q;
  logic [MULT_CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0]      a_q, p_q, m_q, hi_q, lo_q;
  logic                  neg_q, busy_q, done_q;

  logic [WIDTH-1:0]      a_mag_d, b_mag_d, p_d, m_d;
  logic                  neg_d;
  logic [2*WIDTH-1:0]    prod_d;

  // Operand magnitudes; the most negative value maps to itself as unsigned.
  always_comb begin
    a_mag_d = (signedE && srcaE[WIDTH-1]) ? (~srcaE + WIDTH'(1)) : srcaE;
    b_mag_d = (signedE && srcbE[WIDTH-1]) ? (~srcbE + WIDTH'(1)) : srcbE;
    neg_d   = signedE & (srcaE[WIDTH-1] ^ srcbE[WIDTH-1]);
  end

  mult_datapath #(.WIDTH(WIDTH)) u_datapath (
    .a_i    (a_q),
    .p_i    (p_q),
    .m_i    (m_q),
    .neg_i  (neg_q),
    .p_o    (p_d),
    .m_o    (m_d),
    .prod_o (prod_d)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      p_q     <= '0;
      m_q     <= '0;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (mthiW) hi_q <= wdataW;
      if (mtloW) lo_q <= wdataW;
      // A start in any state (re)launches; an aborted op never commits.
      if (start_multE) begin
        a_q     <= a_mag_d;
        p_q     <= '0;
        m_q     <= b_mag_d;
        neg_q   <= neg_d;
        cnt_q   <= '0;
        state_q <= RUN;
        busy_q  <= 1'b1;
      end else begin
        case (state_q)
          RUN: begin
            p_q   <= p_d;
            m_q   <= m_d;
            cnt_q <= cnt_q + MULT_CNT_W'(1);
            if (cnt_q == MULT_CNT_W'(MULT_STEPS - 1)) state_q <= FIX;
          end
          FIX: begin
            // Placed after the mt writes so the commit wins a collision.
            hi_q    <= prod_d[2*WIDTH-1:WIDTH];
            lo_q    <= prod_d[WIDTH-1:0];
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_mult_unit.sv
// Directed self-checking bench for mult_unit.
module tb_mult_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_multE, signedE, mthiW, mtloW;
  logic [31:0] srcaE, srcbE, wdataW;
  logic [31:0] hi, lo;
  logic        busy, done;

  int tests = 0;
  int fails = 0;

  mult_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start_multE (start_multE),
    .signedE     (signedE),
    .srcaE       (srcaE),
    .srcbE       (srcbE),
    .mthiW       (mthiW),
    .mtloW       (mtloW),
    .wdataW      (wdataW),
    .hi          (hi),
    .lo          (lo),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    srcaE = a; srcbE = b; signedE = s; start_multE = 1'b1;
    tick();
    start_multE = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic check_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int lat;
    start_op(a, b, s);
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL %s busy: got %b want 1", name, busy); end
    wait_done(lat);
    tests++;
    if (lat !== 33) begin fails++; $display("FAIL %s latency: got %0d want 33", name, lat); end
    tests++;
    if (hi !== exp_hi || lo !== exp_lo) begin
      fails++;
      $display("FAIL %s product: got %h_%h want %h_%h", name, hi, lo, exp_hi, exp_lo);
    end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL %s busy_at_done: got %b want 0", name, busy); end
  endtask

  task automatic test_reset();
    tests++;
    if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: got hi=%h lo=%h busy=%b done=%b want 0", hi, lo, busy, done);
    end
  endtask

  task automatic test_unsigned();
    check_op("multu_7x6", 32'd7, 32'd6, 1'b0, 32'h0, 32'h2A);
    tick();
    tests++;
    if (done !== 1'b0) begin fails++; $display("FAIL done_pulse_width: got %b want 0", done); end
    check_op("multu_max", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001);
  endtask

  task automatic test_signed();
    tick();
    check_op("mult_m3x5", 32'hFFFFFFFD, 32'd5, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1);
    check_op("mult_m7xm6", 32'hFFFFFFF9, 32'hFFFFFFFA, 1'b1, 32'h0, 32'h2A);
    check_op("mult_min_sq", 32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h0);
  endtask

  task automatic test_back_to_back();
    int lat;
    // currently one cycle after a commit edge: done is high
    start_op(32'h0000FFFF, 32'h0000FFFF, 1'b0);
    tests++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL b2b_restart: got done=%b busy=%b want 0/1", done, busy);
    end
    wait_done(lat);
    tests++;
    if (lat !== 33 || hi !== 32'h0 || lo !== 32'hFFFE0001) begin
      fails++;
      $display("FAIL b2b_result: got lat=%0d %h_%h want 33 00000000_fffe0001", lat, hi, lo);
    end
  endtask

  task automatic test_restart();
    logic [31:0] old_hi, old_lo;
    logic        bad;
    int          lat;
    tick();
    old_hi = hi; old_lo = lo; bad = 1'b0;
    start_op(32'd2, 32'd3, 1'b0);
    for (int i = 0; i < 9; i++) begin
      if (done || hi !== old_hi || lo !== old_lo) bad = 1'b1;
      tick();
    end
    start_op(32'd4, 32'd5, 1'b0);
    lat = 0;
    while (!done && lat < 100) begin
      if (hi !== old_hi || lo !== old_lo) bad = 1'b1;
      tick();
      lat++;
    end
    tests++;
    if (bad !== 1'b0) begin fails++; $display("FAIL restart_no_commit: got %b want 0", bad); end
    tests++;
    if (lat !== 33 || hi !== 32'h0 || lo !== 32'h14) begin
      fails++;
      $display("FAIL restart_result: got lat=%0d %h_%h want 33 00000000_00000014", lat, hi, lo);
    end
  endtask

  task automatic test_mt_collision();
    tick();
    start_op(32'd9, 32'd9, 1'b0);
    repeat (32) tick();
    mthiW = 1'b1; wdataW = 32'hDEAD;
    tick();
    mthiW = 1'b0;
    tests++;
    if (done !== 1'b1 || hi !== 32'h0 || lo !== 32'h51) begin
      fails++;
      $display("FAIL mt_collision: got done=%b %h_%h want 1 00000000_00000051", done, hi, lo);
    end
    mtloW = 1'b1; wdataW = 32'hBEEF;
    tick();
    mtloW = 1'b0;
    tests++;
    if (lo !== 32'hBEEF || hi !== 32'h0) begin
      fails++;
      $display("FAIL mtlo_idle: got %h_%h want 00000000_0000beef", hi, lo);
    end
    mthiW = 1'b1; wdataW = 32'h1234;
    tick();
    mthiW = 1'b0;
    tests++;
    if (hi !== 32'h1234 || lo !== 32'hBEEF) begin
      fails++;
      $display("FAIL mthi_idle: got %h_%h want 00001234_0000beef", hi, lo);
    end
  endtask

  task automatic test_async_reset();
    int lat;
    logic saw_done;
    start_op(32'd7, 32'd6, 1'b0);
    repeat (14) tick();
    #2;
    reset = 1'b1;
    #1;
    tests++;
    if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: got hi=%h lo=%h busy=%b done=%b want 0", hi, lo, busy, done);
    end
    reset = 1'b0;
    saw_done = 1'b0;
    repeat (40) begin
      tick();
      if (done || busy) saw_done = 1'b1;
    end
    tests++;
    if (saw_done !== 1'b0) begin fails++; $display("FAIL post_reset_idle: got %b want 0", saw_done); end
    check_op("after_reset_3x3", 32'd3, 32'd3, 1'b0, 32'h0, 32'h9);
  endtask

  initial begin
    reset = 1'b1; start_multE = 1'b0; signedE = 1'b0;
    srcaE = '0; srcbE = '0; mthiW = 1'b0; mtloW = 1'b0; wdataW = '0;
    #12;
    test_reset();
    reset = 1'b0;
    tick();
    test_reset();
    test_unsigned();
    test_signed();
    test_back_to_back();
    test_restart();
    test_mt_collision();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mult_unit.md
# mult_unit

Iterative 32×32 multiplier that sits in the execute stage, downstream of the hazard detector's `start_multE` handshake. It consumes the E-stage operands of `mult`/`multu`, runs a radix-2 shift-add sequence, and commits a 64-bit product into the architectural HI/LO registers. Those registers are also written by `mthi`/`mtlo` and read by `mfhi`/`mflo`. The hazard detector holds F/D/E for a 64-cycle window per start, and this unit always finishes inside that window.

## Interface
Parameters:
- `WIDTH`, 32: operand width. The product is 2×WIDTH.

Ports:
- `clk`  in  1  pipeline clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `start_multE`  in  1  begin a multiply with the current E operands; the same signal drives the hazard detector
- `signedE`  in  1  1 = `mult` (two's complement), 0 = `multu`
- `srcaE`, `srcbE`  in  WIDTH  multiplicand, multiplier
- `mthiW`, `mtloW`  in  1  writeback write of HI / LO
- `wdataW`  in  WIDTH  data for `mthiW`/`mtloW`
- `hi`, `lo`  out  WIDTH  architectural HI/LO, read combinationally by the `mfhi`/`mflo` path
- `busy`  out  1  multiply in progress
- `done`  out  1  one-cycle pulse; HI/LO hold a new product

## Operation
- States: IDLE, RUN, FIX.
- **IDLE**, `start_multE`=1 → RUN. At that edge the unit captures:
  - `|srcaE|` and `|srcbE|` as magnitudes when `signedE`=1, raw values otherwise. `|0x80000000|` = 0x80000000 as an unsigned magnitude.
  - `neg` = `signedE & (srcaE[31]^srcbE[31])`.
  - Accumulator {P, M}: P=0, M=magnitude B. Step count=0.
- **RUN**, one step per edge:
  - If M[0], P += magnitude A, using a WIDTH+1-bit sum so the carry is kept.
  - {carry, P, M} shifts right by 1.
  - Count increments. After step 31 the state moves to FIX.
- **FIX**:
  - product = `neg` ? −{P,M} : {P,M}, as a 2×WIDTH two's complement.
  - HI/LO are written with product[63:32] and product[31:0].
  - State → IDLE. `done`=1 for the following cycle.
- `start_multE` in RUN or FIX aborts the current operation. The new operands are captured and the state restarts at RUN with count 0, with no HI/LO write and no `done`.
- `mthiW`/`mtloW` write HI/LO in any state. If a write lands on the same edge as the FIX commit, the commit wins and the mt write is dropped.
- `reset`, asserted at any time, forces all of the following immediately, independent of `clk`:
  - state=IDLE, count=0
  - `hi`=`lo`=0
  - `busy`=0, `done`=0
  - accumulator=0

## Timing
- Edge 0 samples `start_multE`.
- Edges 1–32 perform steps 0–31.
- Edge 33 commits HI/LO.
- Latency is 33 cycles from the start edge to new HI/LO. This is well under the hazard detector's 64-cycle stall.
- `busy`=1 from after edge 0 until edge 33, i.e. in RUN and FIX.
- `done`=1 for exactly the one cycle after edge 33, concurrent with the new `hi`/`lo`.
- `hi`/`lo` are registered outputs. An mt write is visible the cycle after its edge.
- Back-to-back: a start on the edge where `done` is high begins a new operation. `done` still deasserts on the next edge.
- Reset values: `hi`=0, `lo`=0, `busy`=0, `done`=0.

## Structure
- Shared package `mult_pkg`:
  - state enum `mult_state_t` {IDLE, RUN, FIX}
  - `MULT_STEPS`=32
  - `MULT_CNT_W`=6
- Sub-module `mult_datapath`:
  - combinational single step: shift-add on {carry, P, M}, plus the final conditional negate.
  - `mult_unit` keeps the FSM, the counter, the operand/accumulator registers and HI/LO.

## Test plan
- Unsigned, and unsigned max:
  - `multu` 7×6 → `done` at cycle 34, `lo`=0x0000002A, `hi`=0.
  - `multu` 0xFFFFFFFF×0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001.
- Signed:
  - `mult` −3×5 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1.
  - `mult` 0x80000000×0x80000000 → `hi`=0x40000000, `lo`=0.
- Restart: start 2×3, then at cycle 10 start 4×5 → single `done` at 33 cycles after the second start, `lo`=0x14, no intermediate HI/LO change.
- mt collision: `mthiW`=1 with `wdataW`=0xDEAD on the commit edge of 9×9 → `hi`=0, `lo`=0x51. `mtloW`=0xBEEF while idle → `lo`=0xBEEF the next cycle.
- Reset: assert `reset` mid-RUN (cycle 15) between clock edges → `busy`/`done`/`hi`/`lo`=0 immediately. After release, no `done` until a new start.
